// File: rtl/sprite_blitter_pkg.sv
// Shared sizes, sprite indices, FSM encoding and the built-in sprite image
// used by the sprite blitter and its ROM.
package sprite_blitter_pkg;

  localparam int SPR_DIM  = 8;
  localparam int NUM_SPR  = 16;
  localparam int COLOUR_W = 3;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int CR_W     = $clog2(SPR_DIM);
  localparam int PIX_W    = 2 * CR_W;
  localparam int ID_W     = $clog2(NUM_SPR);
  localparam int ADDR_W   = ID_W + PIX_W;

  localparam int SCREEN_W_DEFAULT = 160;
  localparam int SCREEN_H_DEFAULT = 120;

  localparam logic [ID_W-1:0] SPR_BLACK       = 4'd0;
  localparam logic [ID_W-1:0] SPR_CRATE       = 4'd1;
  localparam logic [ID_W-1:0] SPR_PLAYER      = 4'd2;
  localparam logic [ID_W-1:0] SPR_WALL        = 4'd3;
  localparam logic [ID_W-1:0] SPR_FLOOR       = 4'd4;
  localparam logic [ID_W-1:0] SPR_CRATE_GOAL  = 4'd5;
  localparam logic [ID_W-1:0] SPR_TITLE_FIRST = 4'd6;
  localparam logic [ID_W-1:0] SPR_TITLE_LAST  = 4'd11;
  localparam logic [ID_W-1:0] SPR_GOAL        = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_DRAW,
    S_DONE
  } blit_state_t;

  // Sprite n starts with n pixels of colour 0 (the key colour); the rest
  // cycle through the non-zero colours so every pixel is distinguishable.
  function automatic logic [COLOUR_W-1:0] sprite_word(input logic [ADDR_W-1:0] addr);
    logic [ID_W-1:0]  id;
    logic [PIX_W-1:0] pix;
    logic [PIX_W:0]   sum;
    id  = addr[ADDR_W-1 -: ID_W];
    pix = addr[PIX_W-1:0];
    sum = {1'b0, pix} + {3'b000, id};
    if ({2'b00, id} > pix) begin
      return '0;
    end
    return COLOUR_W'(sum % 7'd7) + COLOUR_W'(1);
  endfunction

endpackage

// File: rtl/sprite_blitter_if.sv
// Tile-draw interface: the level logic drives the request side, the blitter
// drives the VGA pixel stream and status back.
interface sprite_blitter_if;
  import sprite_blitter_pkg::*;

  logic                begin_draw;
  logic [X_W-1:0]      position_x;
  logic [Y_W-1:0]      position_y;
  logic [ID_W-1:0]     sprite_id;
  logic [X_W-1:0]      vga_x;
  logic [Y_W-1:0]      vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_plot;
  logic                busy;
  logic                done;

  modport master (
    output begin_draw, position_x, position_y, sprite_id,
    input  vga_x, vga_y, vga_colour, vga_plot, busy, done
  );

  modport slave (
    input  begin_draw, position_x, position_y, sprite_id,
    output vga_x, vga_y, vga_colour, vga_plot, busy, done
  );

endinterface

// File: rtl/sprite_blitter_rom.sv
// Synchronous sprite ROM, one-cycle read latency; the output register holds
// its value when not enabled so it doubles as the colour output register.
module sprite_blitter_rom
  import sprite_blitter_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   addr,
  output logic [COLOUR_W-1:0] rd_data
);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= sprite_word(addr);
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Draws one 8x8 sprite per begin_draw rising edge as 64 consecutive pixel
// writes to the VGA adapter, clipping off-screen and optional key pixels.
module sprite_blitter
  import sprite_blitter_pkg::*;
#(
  parameter bit                  KEY_EN     = 1'b0,
  parameter logic [COLOUR_W-1:0] KEY_COLOUR = '0,
  parameter int                  SCREEN_W   = SCREEN_W_DEFAULT,
  parameter int                  SCREEN_H   = SCREEN_H_DEFAULT
) (
  input logic             clock,
  input logic             reset_n,
  sprite_blitter_if.slave tile
);

  localparam logic [X_W:0] X_LIMIT = SCREEN_W[X_W:0];
  localparam logic [Y_W:0] Y_LIMIT = SCREEN_H[Y_W:0];

  blit_state_t         state;
  logic                begin_q;
  logic                busy_q;
  logic                done_q;
  logic                plot_q;
  logic [X_W-1:0]      base_x;
  logic [Y_W-1:0]      base_y;
  logic [ID_W-1:0]     sprite_q;
  logic [PIX_W-1:0]    pix_cnt;
  logic [X_W-1:0]      pix_x;
  logic [Y_W-1:0]      pix_y;
  logic [COLOUR_W-1:0] rom_data;

  logic                start;
  logic                issue;
  logic                in_view;
  logic [CR_W-1:0]     col;
  logic [CR_W-1:0]     row;
  logic [X_W-1:0]      next_x;
  logic [Y_W-1:0]      next_y;

  // A pixel is issued in PRIME and in every DRAW cycle until the counter
  // wraps; the wrapped cycle only drains the last ROM word onto the bus.
  assign start   = tile.begin_draw & ~begin_q;
  assign issue   = (state == S_PRIME) || ((state == S_DRAW) && (pix_cnt != '0));
  assign col     = pix_cnt[CR_W-1:0];
  assign row     = pix_cnt[PIX_W-1:CR_W];
  assign next_x  = base_x + X_W'(col);
  assign next_y  = base_y + Y_W'(row);
  assign in_view = ({1'b0, next_x} < X_LIMIT) && ({1'b0, next_y} < Y_LIMIT);

  sprite_blitter_rom u_rom (
    .clock   (clock),
    .reset_n (reset_n),
    .rd_en   (issue),
    .addr    ({sprite_q, pix_cnt}),
    .rd_data (rom_data)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      begin_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      plot_q   <= 1'b0;
      base_x   <= '0;
      base_y   <= '0;
      sprite_q <= '0;
      pix_cnt  <= '0;
      pix_x    <= '0;
      pix_y    <= '0;
    end else begin
      begin_q <= tile.begin_draw;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            base_x   <= tile.position_x;
            base_y   <= tile.position_y;
            sprite_q <= tile.sprite_id;
            pix_cnt  <= '0;
            busy_q   <= 1'b1;
            state    <= S_PRIME;
          end
        end
        S_PRIME, S_DRAW: begin
          if (issue) begin
            pix_x   <= next_x;
            pix_y   <= next_y;
            plot_q  <= in_view;
            pix_cnt <= pix_cnt + PIX_W'(1);
            state   <= S_DRAW;
          end else begin
            plot_q <= 1'b0;
            done_q <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  // Key test is applied to the colour as it leaves the ROM register, so a
  // keyed pixel still occupies its slot in the fixed-latency stream.
  assign tile.vga_x      = pix_x;
  assign tile.vga_y      = pix_y;
  assign tile.vga_colour = rom_data;
  assign tile.vga_plot   = plot_q && !(KEY_EN && (rom_data == KEY_COLOUR));
  assign tile.busy       = busy_q;
  assign tile.done       = done_q;

endmodule
